cabin_call_arbiter: RTL

Shares one cabin attendant among N_SEATS flight call buttons. Latches each seat's call/cancel into a per-seat pending light and grants the attendant to one pending seat at a time, in round-robin order. Sounds a chime on each new grant and re-chimes while the grant is unacknowledged. Sits between the seat call buttons and the attendant panel; replaces per-seat stand-alone call lights.

---
 rtl/cabin_call_pkg.sv | 20 ++
 rtl/cabin_call_arbiter_rr_pick.sv | 31 +++
 rtl/cabin_call_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cabin_call_pkg.sv
// Shared types and defaults for the cabin call arbiter: FSM state encoding,
// default parameter values and the seat-index width helper.
package cabin_call_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        SERVING = 2'd2
    } state_t;

    localparam int DEF_N_SEATS       = 4;
    localparam int DEF_CHIME_CYCLES  = 4;
    localparam int DEF_REMIND_CYCLES = 16;

    // Width of a seat index; never narrower than one bit.
    function automatic int seat_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cabin_call_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
    import cabin_call_pkg::*;
#(
    parameter  int N = DEF_N_SEATS,
    localparam int W = seat_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cabin_call_arbiter.sv
// Shares one cabin attendant among N_SEATS call buttons: latches call lights,
// grants seats round-robin, chimes on each grant and reminds while unacked.
module cabin_call_arbiter
    import cabin_call_pkg::*;
#(
    parameter  int N_SEATS       = DEF_N_SEATS,
    parameter  int CHIME_CYCLES  = DEF_CHIME_CYCLES,
    parameter  int REMIND_CYCLES = DEF_REMIND_CYCLES,
    localparam int SW            = seat_w(N_SEATS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SEATS-1:0] call,
    input  logic [N_SEATS-1:0] cncl,
    output logic [N_SEATS-1:0] L,
    output logic               grant_valid,
    output logic [SW-1:0]      grant_id,
    output logic               chime,
    output logic               serving,
    input  logic               ack,
    input  logic               done
);

    localparam int CW = $clog2(CHIME_CYCLES + 1);
    localparam int RW = $clog2(REMIND_CYCLES + 1);

    state_t             state_q;
    logic [N_SEATS-1:0] l_q, l_d;
    logic               grant_valid_q;
    logic [SW-1:0]      grant_id_q;
    logic               serving_q;
    logic [SW-1:0]      ptr_q;
    logic [CW-1:0]      chime_cnt_q;
    logic [RW-1:0]      remind_cnt_q;

    logic               pick_found;
    logic [SW-1:0]      pick_idx;
    logic [SW-1:0]      next_ptr;
    logic               in_serving;

    assign in_serving = (state_q == SERVING);
    assign next_ptr   = (grant_id_q == SW'(N_SEATS - 1)) ? '0 : grant_id_q + SW'(1);

    // Cancel beats call; while serving, the granted seat's call is ignored
    // and done clears its light.
    generate
        for (genvar gi = 0; gi < N_SEATS; gi++) begin : g_pend
            logic own;
            assign own     = (grant_id_q == SW'(gi));
            assign l_d[gi] = ~cncl[gi]
                           & ~(in_serving & done & own)
                           & (l_q[gi] | (call[gi] & ~(in_serving & own)));
        end
    endgenerate

    rr_pick #(
        .N (N_SEATS)
    ) u_rr_pick (
        .req   (l_q),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            l_q           <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            serving_q     <= 1'b0;
            ptr_q         <= '0;
            chime_cnt_q   <= '0;
            remind_cnt_q  <= '0;
        end else begin
            l_q <= l_d;
            if (chime_cnt_q != '0) begin
                chime_cnt_q <= chime_cnt_q - CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q       <= ALERT;
                        grant_id_q    <= pick_idx;
                        grant_valid_q <= 1'b1;
                        chime_cnt_q   <= CW'(CHIME_CYCLES);
                        remind_cnt_q  <= RW'(REMIND_CYCLES);
                    end
                end
                ALERT: begin
                    if (cncl[grant_id_q]) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= next_ptr;
                    end else if (ack) begin
                        state_q   <= SERVING;
                        serving_q <= 1'b1;
                    end else if (remind_cnt_q <= RW'(1)) begin
                        // Reminder expires on this edge: repeat the chime.
                        chime_cnt_q  <= CW'(CHIME_CYCLES);
                        remind_cnt_q <= RW'(REMIND_CYCLES);
                    end else begin
                        remind_cnt_q <= remind_cnt_q - RW'(1);
                    end
                end
                SERVING: begin
                    if (done) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        serving_q     <= 1'b0;
                        ptr_q         <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign L           = l_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign chime       = (chime_cnt_q != '0);
    assign serving     = serving_q;

endmodule
